// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with a one-byte holding register, a shift
// register, sticky overrun detection and a bit period latched per frame.
module uart_tx_core #(
  parameter int DATA_W  = 8,
  parameter int MIN_CPB = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              tx_en,
  input  logic [31:0]       clks_per_bit,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  input  logic              ovr_clr,
  output logic              o_tx,
  output logic              txe,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              ovr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [31:0] MIN_CPB_W = 32'(MIN_CPB);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_W - 1);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   hold_reg;
  logic                hold_full;
  logic [DATA_W-1:0]   shift_reg;
  logic [31:0]         cnt;
  logic [31:0]         period_q;
  logic [31:0]         eff_period;
  logic [2:0]          bit_idx;
  logic                stop_idx;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;
  logic                bit_end;
  logic                last_stop;
  logic                frame_end;
  logic                xfer;
  logic                accept;

  assign eff_period = (clks_per_bit < MIN_CPB_W) ? MIN_CPB_W : clks_per_bit;
  assign bit_end    = (cnt == 32'd0);
  assign last_stop  = !stop2_q || stop_idx;
  assign frame_end  = (state == STOP) && bit_end && last_stop;
  // A frame starts from IDLE, or straight out of the last stop clock when
  // another byte is already waiting (no idle gap between frames).
  assign xfer       = hold_full && tx_en && ((state == IDLE) || frame_end);
  // A write landing on the transfer cycle refills the register being emptied.
  assign accept     = tx_wr && (!hold_full || xfer);

  assign txe     = !hold_full;
  assign tx_busy = (state != IDLE);

  // State register; reset drops the frame and returns the line to idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus line level and end-of-frame pulse.
  always_comb begin
    state_next = state;
    o_tx       = 1'b1;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) state_next = START;
      end
      START: begin
        o_tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        o_tx = shift_reg[0];
        if (bit_end && (bit_idx == LAST_BIT))
          state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        o_tx = par_bit_q;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (frame_end) begin
          tx_done    = 1'b1;
          state_next = xfer ? START : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register, its full flag, and the sticky overrun flag.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (accept) hold_reg <= tx_data;
      if (accept)    hold_full <= 1'b1;
      else if (xfer) hold_full <= 1'b0;
      if (tx_wr && !accept) ovr <= 1'b1;
      else if (ovr_clr)     ovr <= 1'b0;
    end
  end

  // Frame datapath: per-frame settings are captured at transfer so that
  // register changes mid-frame only affect the next frame.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      shift_reg <= '0;
      cnt       <= '0;
      period_q  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (xfer) begin
      shift_reg <= hold_reg;
      cnt       <= eff_period - 32'd1;
      period_q  <= eff_period;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_en_q  <= parity_en;
      par_bit_q <= (^hold_reg) ^ parity_odd;
      stop2_q   <= stop2;
    end else if (state != IDLE) begin
      if (bit_end) begin
        cnt <= period_q - 32'd1;
        if (state == DATA) begin
          shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
          bit_idx   <= bit_idx + 3'd1;
        end
        if (state == STOP) stop_idx <= !stop_idx;
      end else begin
        cnt <= cnt - 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: vector table, directed multi-cycle
// sequences and randomized frames compared against a frame-level model.
module tb_uart_tx_core;

  localparam int MAXS = 600;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic        tx_en = 1'b1;
  logic [31:0] clks_per_bit = 32'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        o_tx, txe, tx_busy, tx_done, ovr;

  always #5 PCLK = ~PCLK;

  uart_tx_core #(.DATA_W(8), .MIN_CPB(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .tx_en(tx_en), .clks_per_bit(clks_per_bit),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_data(tx_data), .tx_wr(tx_wr), .ovr_clr(ovr_clr),
    .o_tx(o_tx), .txe(txe), .tx_busy(tx_busy), .tx_done(tx_done), .ovr(ovr)
  );

  int checks = 0;
  int failures = 0;

  logic       cap_tx[MAXS], cap_done[MAXS], cap_busy[MAXS], cap_txe[MAXS], cap_ovr[MAXS];
  logic       exp_tx[MAXS], exp_done[MAXS], exp_busy[MAXS];
  logic       inj_wr[MAXS], inj_clr[MAXS], inj_en[MAXS];
  logic [7:0] inj_data[MAXS];
  int         cpb_chg_at;
  logic [31:0] cpb_chg_val;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         pe, po, s2;
    int         period;
    bit         par;
    int         len;
  } vec_t;

  vec_t vecs[7];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic clear_seq();
    for (int i = 0; i < MAXS; i++) begin
      inj_wr[i] = 1'b0; inj_clr[i] = 1'b0; inj_en[i] = 1'b1; inj_data[i] = 8'h00;
      exp_tx[i] = 1'b1; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
    end
    cpb_chg_at = -1;
    cpb_chg_val = 32'd0;
  endtask

  // Sample i is taken on a falling edge; the inputs set after it are seen
  // by the next rising edge, so their effect shows from sample i+1.
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      cap_tx[i] = o_tx; cap_done[i] = tx_done; cap_busy[i] = tx_busy;
      cap_txe[i] = txe; cap_ovr[i] = ovr;
      tx_wr = inj_wr[i]; tx_data = inj_data[i]; ovr_clr = inj_clr[i]; tx_en = inj_en[i];
      if (i == cpb_chg_at) clks_per_bit = cpb_chg_val;
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stop
  // bits, each bit lasting max(cpb, 4) clocks.
  task automatic place_frame(input int start, input logic [7:0] d, input int cpb,
                             input bit pe, input bit po, input bit s2, output int last);
    int p;
    int k;
    bit bits[$];
    p = (cpb < 4) ? 4 : cpb;
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(d[b]);
    if (pe) bits.push_back((^d) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    k = start;
    foreach (bits[j]) begin
      for (int r = 0; r < p; r++) begin
        exp_tx[k] = bits[j]; exp_busy[k] = 1'b1; k++;
      end
    end
    last = k - 1;
    exp_done[last] = 1'b1;
  endtask

  task automatic check_waves(input string name, input int n);
    int bt, bd, bb, ft, fd, fb;
    bt = 0; bd = 0; bb = 0; ft = -1; fd = -1; fb = -1;
    for (int i = 0; i < n; i++) begin
      if (cap_tx[i] !== exp_tx[i]) begin bt++; if (ft < 0) ft = i; end
      if (cap_done[i] !== exp_done[i]) begin bd++; if (fd < 0) fd = i; end
      if (cap_busy[i] !== exp_busy[i]) begin bb++; if (fb < 0) fb = i; end
    end
    checks += 3;
    if (bt != 0) begin
      failures++;
      $display("FAIL %s o_tx: %0d wrong samples, first at %0d got %b expected %b",
               name, bt, ft, cap_tx[ft], exp_tx[ft]);
    end
    if (bd != 0) begin
      failures++;
      $display("FAIL %s tx_done: %0d wrong samples, first at %0d got %b expected %b",
               name, bd, fd, cap_done[fd], exp_done[fd]);
    end
    if (bb != 0) begin
      failures++;
      $display("FAIL %s tx_busy: %0d wrong samples, first at %0d got %b expected %b",
               name, bb, fb, cap_busy[fb], exp_busy[fb]);
    end
  endtask

  task automatic set_cfg(input int cpb, input bit pe, input bit po, input bit s2);
    clks_per_bit = 32'(cpb); parity_en = pe; parity_odd = po; stop2 = s2;
  endtask

  initial begin
    int last, last2, didx, n;
    logic [9:0] a5_bits;
    logic [9:0] a5_got;

    vecs[0] = '{8'hA5, 4, 1'b0, 1'b0, 1'b0, 4, 1'b0, 40};
    vecs[1] = '{8'h07, 2, 1'b1, 1'b0, 1'b1, 4, 1'b1, 48};
    vecs[2] = '{8'h00, 5, 1'b1, 1'b1, 1'b0, 5, 1'b1, 55};
    vecs[3] = '{8'hFF, 0, 1'b1, 1'b0, 1'b0, 4, 1'b0, 44};
    vecs[4] = '{8'h3C, 6, 1'b0, 1'b0, 1'b1, 6, 1'b0, 66};
    vecs[5] = '{8'h80, 1, 1'b1, 1'b1, 1'b1, 4, 1'b0, 48};
    vecs[6] = '{8'h5B, 7, 1'b1, 1'b0, 1'b0, 7, 1'b1, 77};

    // Reset values, asserted before any clock edge
    #1 PRESET = 1'b1;
    #1;
    check1("rst_o_tx", 32'(o_tx), 32'd1);
    check1("rst_txe", 32'(txe), 32'd1);
    check1("rst_busy", 32'(tx_busy), 32'd0);
    check1("rst_done", 32'(tx_done), 32'd0);
    check1("rst_ovr", 32'(ovr), 32'd0);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;

    // Vector table
    foreach (vecs[v]) begin
      clear_seq();
      set_cfg(vecs[v].cpb, vecs[v].pe, vecs[v].po, vecs[v].s2);
      inj_wr[0] = 1'b1; inj_data[0] = vecs[v].data;
      place_frame(2, vecs[v].data, vecs[v].cpb, vecs[v].pe, vecs[v].po, vecs[v].s2, last);
      n = vecs[v].len + 6;
      run_seq(n);
      check_waves($sformatf("vec%0d", v), n);
      didx = -1;
      for (int i = n - 1; i >= 0; i--) if (cap_done[i] === 1'b1) didx = i;
      check1($sformatf("vec%0d_len", v), 32'(didx - 1), 32'(vecs[v].len));
      check1($sformatf("vec%0d_txe_low", v), {30'd0, cap_txe[1], cap_txe[2]}, 32'b01);
      if (vecs[v].pe)
        check1($sformatf("vec%0d_parity", v),
               32'(cap_tx[2 + 9 * vecs[v].period + vecs[v].period / 2]), 32'(vecs[v].par));
      if (v == 0) begin
        a5_bits = 10'b1101001010;
        for (int b = 0; b < 10; b++) a5_got[b] = cap_tx[2 + 4 * b + 2];
        check1("a5_bits", 32'(a5_got), 32'(a5_bits));
      end
    end

    // Back-to-back: second byte written during the first start bit
    clear_seq();
    set_cfg(4, 1'b0, 1'b0, 1'b0);
    inj_wr[0] = 1'b1; inj_data[0] = 8'h11;
    inj_wr[3] = 1'b1; inj_data[3] = 8'h22;
    place_frame(2, 8'h11, 4, 1'b0, 1'b0, 1'b0, last);
    place_frame(last + 1, 8'h22, 4, 1'b0, 1'b0, 1'b0, last2);
    run_seq(last2 + 5);
    check_waves("b2b", last2 + 5);
    check1("b2b_txe_rise", {30'd0, cap_txe[41], cap_txe[42]}, 32'b01);
    check1("b2b_ovr", 32'(cap_ovr[last2 + 4]), 32'd0);

    // Write on the exact transfer cycle is accepted
    clear_seq();
    inj_wr[0] = 1'b1; inj_data[0] = 8'h5A;
    inj_wr[1] = 1'b1; inj_data[1] = 8'hC3;
    place_frame(2, 8'h5A, 4, 1'b0, 1'b0, 1'b0, last);
    place_frame(last + 1, 8'hC3, 4, 1'b0, 1'b0, 1'b0, last2);
    run_seq(last2 + 5);
    check_waves("xfer_wr", last2 + 5);
    check1("xfer_wr_txe", 32'(cap_txe[2]), 32'd0);
    check1("xfer_wr_ovr", 32'(cap_ovr[last2 + 4]), 32'd0);

    // Overrun: 0x55 and 0x77 dropped, clear racing a new overrun keeps ovr
    clear_seq();
    inj_wr[0] = 1'b1; inj_data[0] = 8'h33;
    inj_wr[2] = 1'b1; inj_data[2] = 8'h44;
    inj_wr[4] = 1'b1; inj_data[4] = 8'h55;
    inj_wr[6] = 1'b1; inj_data[6] = 8'h77; inj_clr[6] = 1'b1;
    inj_clr[10] = 1'b1;
    place_frame(2, 8'h33, 4, 1'b0, 1'b0, 1'b0, last);
    place_frame(last + 1, 8'h44, 4, 1'b0, 1'b0, 1'b0, last2);
    run_seq(last2 + 5);
    check_waves("ovr", last2 + 5);
    check1("ovr_before", 32'(cap_ovr[3]), 32'd0);
    check1("ovr_set", 32'(cap_ovr[5]), 32'd1);
    check1("ovr_clr_race", 32'(cap_ovr[8]), 32'd1);
    check1("ovr_cleared", 32'(cap_ovr[12]), 32'd0);

    // tx_en low holds the byte; raising it starts the frame next cycle
    clear_seq();
    for (int i = 0; i < 10; i++) inj_en[i] = 1'b0;
    inj_wr[0] = 1'b1; inj_data[0] = 8'h66;
    place_frame(11, 8'h66, 4, 1'b0, 1'b0, 1'b0, last);
    run_seq(last + 5);
    check_waves("txen", last + 5);
    check1("txen_txe", {30'd0, cap_txe[10], cap_txe[11]}, 32'b01);

    // Reset in the middle of data bit 3
    clear_seq();
    inj_wr[0] = 1'b1; inj_data[0] = 8'h00;
    place_frame(2, 8'h00, 4, 1'b0, 1'b0, 1'b0, last);
    run_seq(20);
    check_waves("pre_rst", 20);
    #2 PRESET = 1'b1;
    #1;
    check1("midrst_o_tx", 32'(o_tx), 32'd1);
    check1("midrst_busy", 32'(tx_busy), 32'd0);
    check1("midrst_txe", 32'(txe), 32'd1);
    check1("midrst_ovr", 32'(ovr), 32'd0);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    clear_seq();
    run_seq(60);
    check_waves("post_rst", 60);
    check1("post_rst_txe", 32'(cap_txe[59]), 32'd1);

    // Randomized frames: mid-frame period change, tx_en dips, optional
    // second byte queued during the start bit
    for (int t = 0; t < 20; t++) begin
      logic [7:0] d, d2;
      int cpb, en_off, k;
      bit pe, po, s2;
      clear_seq();
      d = 8'($urandom); cpb = int'($urandom_range(0, 9));
      pe = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
      set_cfg(cpb, pe, po, s2);
      inj_wr[0] = 1'b1; inj_data[0] = d;
      cpb_chg_at = int'($urandom_range(3, 10));
      cpb_chg_val = 32'($urandom_range(0, 9));
      en_off = int'($urandom_range(3, 8));
      for (int e = en_off; e < en_off + 4; e++) inj_en[e] = 1'b0;
      place_frame(2, d, cpb, pe, po, s2, last);
      if ($urandom_range(0, 1) == 1) begin
        d2 = 8'($urandom);
        k = 2 + int'($urandom_range(0, 3));
        inj_wr[k] = 1'b1; inj_data[k] = d2;
        place_frame(last + 1, d2, int'(cpb_chg_val), pe, po, s2, last);
      end
      run_seq(last + 5);
      check_waves($sformatf("rand%0d", t), last + 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
